approx_add_err_monitor: RTL and testbench

Streaming error-characterization block for approximate adders. Accepts operand pairs and the approximate sum produced by an adder under test. Computes the exact sum and the signed error, and accumulates run statistics: sample count, error count, worst-case error, sum of absolute errors and sum of squared errors. The MAE, WCE, EP and MSE figures quoted for each circuit are derived in silicon or emulation from these statistics.

---
 rtl/approx_add_err_monitor.sv | 137 +++++++++++++
 tb/tb_approx_add_err_monitor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_add_err_monitor.sv
// Error-characterization monitor for approximate adders: compares an adder's
// result against the exact sum and accumulates run statistics over a sample run.
module approx_add_err_monitor #(
   parameter int W     = 16,
   parameter int CNT_W = 32,
   parameter int ACC_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [W:0]       in_o,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [W:0]       wce,
   output logic [ACC_W-1:0] sum_abs,
   output logic [ACC_W-1:0] sum_sq,
   output logic             sat
);

   localparam int SQ_W  = 2 * W + 2;
   localparam int EXT_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] target;
   logic [CNT_W-1:0] acc_cnt;
   logic             xfer;

   logic [W:0]       exact;
   logic [W+1:0]     err;
   logic [W+1:0]     err_neg;
   logic [W:0]       abs_err;

   logic             s1_valid;
   logic [W:0]       s1_abs;
   logic             s1_nz;

   logic [SQ_W-1:0]  sq;
   logic [EXT_W-1:0] acc_max;
   logic [EXT_W-1:0] abs_ext;
   logic [EXT_W-1:0] sq_ext;
   logic             abs_sat;
   logic             sq_sat;

   // start outranks a same-cycle transfer, which is dropped.
   assign xfer = in_valid && in_ready && !start;

   // Stage 1 arithmetic: the sign bit of err is bit W+1.
   assign exact   = {1'b0, in_a} + {1'b0, in_b};
   assign err     = {1'b0, in_o} - {1'b0, exact};
   assign err_neg = ~err + 1'b1;
   assign abs_err = err[W+1] ? err_neg[W:0] : err[W:0];

   // Stage 2 arithmetic, widened by one bit so overflow is visible.
   assign sq      = {{(W+1){1'b0}}, s1_abs} * {{(W+1){1'b0}}, s1_abs};
   assign acc_max = {{(EXT_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};
   assign abs_ext = EXT_W'(sum_abs) + EXT_W'(s1_abs);
   assign sq_ext  = EXT_W'(sum_sq) + EXT_W'(sq);
   assign abs_sat = abs_ext > acc_max;
   assign sq_sat  = sq_ext > acc_max;

   // NOTE: stage-1 data needs no reset; s1_valid alone decides whether it is used.
   always_ff @(posedge clk) begin
      s1_abs <= abs_err;
      s1_nz  <= (err != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         target     <= '0;
         acc_cnt    <= '0;
         s1_valid   <= 1'b0;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         sample_cnt <= '0;
         err_cnt    <= '0;
         wce        <= '0;
         sum_abs    <= '0;
         sum_sq     <= '0;
         sat        <= 1'b0;
      end else if (start) begin
         target     <= num_samples;
         acc_cnt    <= '0;
         s1_valid   <= 1'b0;
         sample_cnt <= '0;
         err_cnt    <= '0;
         wce        <= '0;
         sum_abs    <= '0;
         sum_sq     <= '0;
         sat        <= 1'b0;
         state      <= (num_samples != '0) ? RUN : DONE;
         in_ready   <= (num_samples != '0);
         busy       <= (num_samples != '0);
         done       <= (num_samples == '0);
      end else begin
         s1_valid <= xfer;
         if (s1_valid) begin
            sample_cnt <= sample_cnt + 1'b1;
            err_cnt    <= err_cnt + CNT_W'(s1_nz);
            wce        <= (s1_abs > wce) ? s1_abs : wce;
            sum_abs    <= abs_sat ? {ACC_W{1'b1}} : abs_ext[ACC_W-1:0];
            sum_sq     <= sq_sat ? {ACC_W{1'b1}} : sq_ext[ACC_W-1:0];
            if (abs_sat || sq_sat) sat <= 1'b1;
         end
         case (state)
            RUN: begin
               if (xfer) begin
                  acc_cnt <= acc_cnt + 1'b1;
                  if (acc_cnt == target - 1'b1) begin
                     state    <= DRAIN;
                     in_ready <= 1'b0;
                  end
               end
            end
            // The final sample leaves stage 1 on this edge, so done appears
            // together with its statistics.
            DRAIN: begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Directed bench for approx_add_err_monitor: single-sample vector table plus
// hand-written multi-cycle sequences (streams, backpressure, abort, saturation).
module tb_approx_add_err_monitor;

   logic        clk = 1'b0;
   logic        rst, start, in_valid;
   logic [31:0] num_samples;
   logic [15:0] in_a, in_b;
   logic [16:0] in_o;

   logic        in_ready, busy, done, sat;
   logic [31:0] sample_cnt, err_cnt;
   logic [16:0] wce;
   logic [63:0] sum_abs, sum_sq;

   logic        s_in_ready, s_busy, s_done, s_sat;
   logic [31:0] s_sample_cnt, s_err_cnt;
   logic [16:0] s_wce;
   logic [19:0] s_sum_abs, s_sum_sq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   approx_add_err_monitor #(.W(16), .CNT_W(32), .ACC_W(64)) dut (
      .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_o(in_o),
      .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
      .wce(wce), .sum_abs(sum_abs), .sum_sq(sum_sq), .sat(sat)
   );

   // Narrow-accumulator copy driven by the same stimulus, used for saturation.
   approx_add_err_monitor #(.W(16), .CNT_W(32), .ACC_W(20)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b), .in_o(in_o),
      .busy(s_busy), .done(s_done), .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt),
      .wce(s_wce), .sum_abs(s_sum_abs), .sum_sq(s_sum_sq), .sat(s_sat)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [16:0] o;
      logic [31:0] ecnt;
      logic [16:0] wce;
      logic [63:0] sabs;
      logic [63:0] ssq;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] n);
      start       = 1'b1;
      num_samples = n;
      step();
      start       = 1'b0;
   endtask

   // Offer one triple and return #1 after the edge that accepts it.
   task automatic put(input logic [15:0] a, input logic [15:0] b, input logic [16:0] o);
      int n = 0;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_o = o;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      vecs[0] = '{16'd0,      16'd0,      17'd5,       32'd1, 17'd5,      64'd5,      64'd25};
      vecs[1] = '{16'd3,      16'd4,      17'd7,       32'd0, 17'd0,      64'd0,      64'd0};
      vecs[2] = '{16'd10,     16'd0,      17'd3,       32'd1, 17'd7,      64'd7,      64'd49};
      vecs[3] = '{16'hFFFF,   16'hFFFF,   17'd0,       32'd1, 17'd131070, 64'd131070, 64'd17179344900};
      vecs[4] = '{16'd0,      16'd0,      17'h1FFFF,   32'd1, 17'd131071, 64'd131071, 64'd17179607041};
      vecs[5] = '{16'h8000,   16'h8000,   17'h0FFFF,   32'd1, 17'd1,      64'd1,      64'd1};
      vecs[6] = '{16'd100,    16'd200,    17'd1300,    32'd1, 17'd1000,   64'd1000,   64'd1000000};
      vecs[7] = '{16'h1234,   16'h4321,   17'h05555,   32'd0, 17'd0,      64'd0,      64'd0};

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_samples = '0;
      in_a = '0; in_b = '0; in_o = '0;
      step(); step();
      rst = 1'b0;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_sat", 64'(sat), 64'd0);
      check("rst_sample_cnt", 64'(sample_cnt), 64'd0);
      check("rst_sum_sq", sum_sq, 64'd0);

      for (int i = 0; i < 8; i++) begin
         do_start(32'd1);
         check($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
         put(vecs[i].a, vecs[i].b, vecs[i].o);
         check($sformatf("v%0d_ready_low", i), 64'(in_ready), 64'd0);
         check($sformatf("v%0d_done_early", i), 64'(done), 64'd0);
         step();
         check($sformatf("v%0d_done", i), 64'(done), 64'd1);
         check($sformatf("v%0d_sample_cnt", i), 64'(sample_cnt), 64'd1);
         check($sformatf("v%0d_err_cnt", i), 64'(err_cnt), 64'(vecs[i].ecnt));
         check($sformatf("v%0d_wce", i), 64'(wce), 64'(vecs[i].wce));
         check($sformatf("v%0d_sum_abs", i), sum_abs, vecs[i].sabs);
         check($sformatf("v%0d_sum_sq", i), sum_sq, vecs[i].ssq);
      end

      // Exact stream of four back-to-back samples.
      do_start(32'd4);
      put(16'd1, 16'd2, 17'd3);
      put(16'd100, 16'd200, 17'd300);
      put(16'hFFFF, 16'd1, 17'h10000);
      put(16'd0, 16'd0, 17'd0);
      check("exact_ready_low", 64'(in_ready), 64'd0);
      check("exact_done_early", 64'(done), 64'd0);
      check("exact_busy", 64'(busy), 64'd1);
      step();
      check("exact_done", 64'(done), 64'd1);
      check("exact_busy_low", 64'(busy), 64'd0);
      check("exact_sample_cnt", 64'(sample_cnt), 64'd4);
      check("exact_err_cnt", 64'(err_cnt), 64'd0);
      check("exact_wce", 64'(wce), 64'd0);
      check("exact_sum_abs", sum_abs, 64'd0);
      check("exact_sum_sq", sum_sq, 64'd0);
      check("exact_sat", 64'(sat), 64'd0);

      // Mixed errors accumulated within one run.
      do_start(32'd3);
      put(16'd0, 16'd0, 17'd5);
      put(16'd3, 16'd4, 17'd7);
      put(16'd10, 16'd0, 17'd3);
      step();
      check("mix_done", 64'(done), 64'd1);
      check("mix_sample_cnt", 64'(sample_cnt), 64'd3);
      check("mix_err_cnt", 64'(err_cnt), 64'd2);
      check("mix_wce", 64'(wce), 64'd7);
      check("mix_sum_abs", sum_abs, 64'd12);
      check("mix_sum_sq", sum_sq, 64'd74);
      step();
      check("mix_hold_sum_sq", sum_sq, 64'd74);

      // Backpressure: in_valid pattern 1,0,1,1,1,1 against num_samples=3.
      begin
         logic [5:0] vpat;
         int         xfers;
         int         last_xfer;
         vpat = 6'b111101;
         xfers = 0;
         last_xfer = -1;
         do_start(32'd3);
         for (int c = 0; c < 6; c++) begin
            in_valid = vpat[c];
            in_a = 16'(c);
            in_b = 16'(c);
            in_o = 17'(2 * c);
            if (c == last_xfer + 1 && xfers == 3)
               check("bp_ready_after_last", 64'(in_ready), 64'd0);
            if (in_valid && in_ready) begin
               xfers++;
               last_xfer = c;
            end
            step();
         end
         in_valid = 1'b0;
         check("bp_xfers", 64'(xfers), 64'd3);
         check("bp_last_xfer_cycle", 64'(last_xfer), 64'd3);
         check("bp_done", 64'(done), 64'd1);
         check("bp_sample_cnt", 64'(sample_cnt), 64'd3);
         check("bp_err_cnt", 64'(err_cnt), 64'd0);
      end

      // Abort after two transfers; the same-cycle offered triple is dropped.
      do_start(32'd5);
      put(16'd0, 16'd0, 17'd5);
      put(16'd0, 16'd0, 17'd5);
      check("abort_mid_cnt", 64'(sample_cnt), 64'd1);
      in_valid = 1'b1;
      in_a = 16'd0; in_b = 16'd0; in_o = 17'd9;
      do_start(32'd1);
      check("abort_sample_cnt", 64'(sample_cnt), 64'd0);
      check("abort_sum_abs", sum_abs, 64'd0);
      check("abort_busy", 64'(busy), 64'd1);
      put(16'd1, 16'd1, 17'd3);
      step();
      step();
      check("abort_done", 64'(done), 64'd1);
      check("abort_final_cnt", 64'(sample_cnt), 64'd1);
      check("abort_final_abs", sum_abs, 64'd1);

      // Zero-length run.
      do_start(32'd0);
      check("zero_done", 64'(done), 64'd1);
      check("zero_busy", 64'(busy), 64'd0);
      check("zero_ready", 64'(in_ready), 64'd0);
      check("zero_sample_cnt", 64'(sample_cnt), 64'd0);

      // Saturation on the narrow-accumulator instance.
      do_start(32'd1);
      put(16'd0, 16'd0, 17'd1024);
      step();
      check("sat_done", 64'(s_done), 64'd1);
      check("sat_sum_sq", 64'(s_sum_sq), 64'hFFFFF);
      check("sat_flag", 64'(s_sat), 64'd1);
      check("sat_sum_abs", 64'(s_sum_abs), 64'd1024);
      check("sat_wide_sum_sq", sum_sq, 64'd1048576);
      check("sat_wide_flag", 64'(sat), 64'd0);
      do_start(32'd0);
      check("sat_cleared", 64'(s_sat), 64'd0);
      check("sat_sq_cleared", 64'(s_sum_sq), 64'd0);

      // Reset in the middle of a run.
      do_start(32'd3);
      put(16'd0, 16'd0, 17'd9);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rstmid_busy", 64'(busy), 64'd0);
      check("rstmid_ready", 64'(in_ready), 64'd0);
      check("rstmid_done", 64'(done), 64'd0);
      step();
      check("rstmid_sample_cnt", 64'(sample_cnt), 64'd0);
      check("rstmid_sum_abs", sum_abs, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
